// File: rtl/axil_reg_slice.sv
// axil_reg_slice: AXI4-Lite register slice, per-channel bypass / forward register / full skid buffer.
module axil_slice #(
    parameter int MODE = 2,
    parameter int W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    if (MODE == 0) begin : g_bypass
        logic unused;
        assign unused    = ^{clk, rst};
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
    end else if (MODE == 1) begin : g_fwd
        logic         v_q;
        logic [W-1:0] d_q;
        assign in_ready  = !v_q | out_ready;
        assign out_valid = v_q;
        assign out_data  = d_q;
        always_ff @(posedge clk)
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (in_valid && in_ready) begin
                v_q <= 1'b1;
                d_q <= in_data;
            end else if (out_ready) begin
                v_q <= 1'b0;
            end
    end else begin : g_skid
        state_t       st;
        logic [W-1:0] main_q, skid_q;
        logic         rdy_q;
        logic         in_fire;
        assign in_fire   = in_valid & rdy_q;
        assign in_ready  = rdy_q;
        assign out_valid = st != EMPTY;
        assign out_data  = main_q;
        // rdy_q tracks next_state != FULL; it stays low through reset
        always_ff @(posedge clk)
            if (rst) begin
                st     <= EMPTY;
                main_q <= '0;
                skid_q <= '0;
                rdy_q  <= 1'b0;
            end else begin
                rdy_q <= 1'b1;
                case (st)
                    EMPTY: if (in_fire) begin
                        main_q <= in_data;
                        st     <= ONE;
                    end
                    ONE: if (in_fire && out_ready) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        st     <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (out_ready) begin
                        st <= EMPTY;
                    end
                    FULL: if (out_ready) begin
                        main_q <= skid_q;
                        st     <= ONE;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                    default: st <= EMPTY;
                endcase
            end
    end
endmodule

module axil_reg_slice #(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int AW_MODE = 2,
    parameter  int W_MODE  = 2,
    parameter  int B_MODE  = 1,
    parameter  int AR_MODE = 2,
    parameter  int R_MODE  = 1,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [DATA_W-1:0] s_axil_wdata,
    input  logic [STRB_W-1:0] s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [DATA_W-1:0] s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [DATA_W-1:0] m_axil_wdata,
    output logic [STRB_W-1:0] m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    output logic [ADDR_W-1:0] m_axil_araddr,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);
    axil_slice #(.MODE(AW_MODE), .W(ADDR_W)) u_aw (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_awvalid), .in_data(s_axil_awaddr), .in_ready(s_axil_awready),
        .out_valid(m_axil_awvalid), .out_data(m_axil_awaddr), .out_ready(m_axil_awready)
    );
    axil_slice #(.MODE(W_MODE), .W(DATA_W + STRB_W)) u_w (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_wvalid), .in_data({s_axil_wdata, s_axil_wstrb}), .in_ready(s_axil_wready),
        .out_valid(m_axil_wvalid), .out_data({m_axil_wdata, m_axil_wstrb}), .out_ready(m_axil_wready)
    );
    axil_slice #(.MODE(B_MODE), .W(2)) u_b (
        .clk(aclk), .rst(areset),
        .in_valid(m_axil_bvalid), .in_data(m_axil_bresp), .in_ready(m_axil_bready),
        .out_valid(s_axil_bvalid), .out_data(s_axil_bresp), .out_ready(s_axil_bready)
    );
    axil_slice #(.MODE(AR_MODE), .W(ADDR_W)) u_ar (
        .clk(aclk), .rst(areset),
        .in_valid(s_axil_arvalid), .in_data(s_axil_araddr), .in_ready(s_axil_arready),
        .out_valid(m_axil_arvalid), .out_data(m_axil_araddr), .out_ready(m_axil_arready)
    );
    axil_slice #(.MODE(R_MODE), .W(DATA_W + 2)) u_r (
        .clk(aclk), .rst(areset),
        .in_valid(m_axil_rvalid), .in_data({m_axil_rdata, m_axil_rresp}), .in_ready(m_axil_rready),
        .out_valid(s_axil_rvalid), .out_data({s_axil_rdata, s_axil_rresp}), .out_ready(s_axil_rready)
    );
endmodule

// File: tb/tb_axil_reg_slice.sv
// tb_axil_reg_slice: directed and random checks of the default-mode slice and an all-bypass slice.
module tb_axil_reg_slice;
    logic aclk = 1'b0, areset = 1'b1;
    logic [31:0] s_awaddr, s_wdata, s_araddr, m_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [31:0] m_awaddr, m_wdata, m_araddr, s_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr_z, m_wdata_z, m_araddr_z, s_rdata_z;
    logic [3:0]  m_wstrb_z;
    logic [1:0]  s_bresp_z, s_rresp_z;
    logic s_awready_z, s_wready_z, s_bvalid_z, s_arready_z, s_rvalid_z;
    logic m_awvalid_z, m_wvalid_z, m_bready_z, m_arvalid_z, m_rready_z;
    int n_chk = 0, n_fail = 0;

    always #5 aclk = ~aclk;

    axil_reg_slice dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
        .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
        .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
        .s_axil_araddr(s_araddr), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    axil_reg_slice #(.AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0)) dut0 (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready_z),
        .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready_z),
        .s_axil_bresp(s_bresp_z), .s_axil_bvalid(s_bvalid_z), .s_axil_bready(s_bready),
        .s_axil_araddr(s_araddr), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready_z),
        .s_axil_rdata(s_rdata_z), .s_axil_rresp(s_rresp_z), .s_axil_rvalid(s_rvalid_z), .s_axil_rready(s_rready),
        .m_axil_awaddr(m_awaddr_z), .m_axil_awvalid(m_awvalid_z), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata_z), .m_axil_wstrb(m_wstrb_z), .m_axil_wvalid(m_wvalid_z), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready_z),
        .m_axil_araddr(m_araddr_z), .m_axil_arvalid(m_arvalid_z), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready_z)
    );

    task automatic idle;
        {s_awaddr, s_wdata, s_wstrb, s_araddr, m_bresp, m_rdata, m_rresp} = '0;
        {s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid} = '0;
        {s_bready, s_rready, m_awready, m_wready, m_arready} = '1;
    endtask

    task automatic test_reset;
        idle();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        n_chk++;
        if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 00000", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid});
        end
        n_chk++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready_q: got %b expected 000", {s_awready, s_wready, s_arready});
        end
        n_chk++;
        if ({m_bready, m_rready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready_fwd: got %b expected 11", {m_bready, m_rready});
        end
        n_chk++;
        if ({m_awaddr, m_wdata, m_wstrb, m_araddr, s_bresp, s_rdata, s_rresp} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {m_awaddr, m_wdata, m_wstrb, m_araddr, s_bresp, s_rdata, s_rresp});
        end
        areset = 1'b0;
        @(negedge aclk);
        n_chk++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            n_fail++; $display("FAIL release_ready: got %b expected 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_aw_stream;
        logic [31:0] a [3];
        a = '{32'h10, 32'h14, 32'h18};
        s_awvalid = 1'b1;
        s_awaddr  = a[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_chk++;
            if ({m_awvalid, m_awaddr, s_awready} !== {1'b1, a[i], 1'b1}) begin
                n_fail++; $display("FAIL aw_stream[%0d]: got v=%b a=%h r=%b expected v=1 a=%h r=1", i, m_awvalid, m_awaddr, s_awready, a[i]);
            end
            if (i < 2) s_awaddr = a[i+1];
            else s_awvalid = 1'b0;
        end
        @(negedge aclk);
        n_chk++;
        if (m_awvalid !== 1'b0) begin
            n_fail++; $display("FAIL aw_drain: got %b expected 0", m_awvalid);
        end
    endtask

    task automatic test_w_backpressure;
        logic [31:0] wd [3];
        logic [3:0]  ws [3];
        int          ei [5];
        logic        er [5];
        wd = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
        ws = '{4'h1, 4'h2, 4'h4};
        ei = '{0, 0, 0, 1, 2};
        er = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        s_wvalid = 1'b1;
        s_wdata  = wd[0];
        s_wstrb  = ws[0];
        m_wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            n_chk++;
            if ({m_wvalid, m_wdata, m_wstrb, s_wready} !== {1'b1, wd[ei[k]], ws[ei[k]], er[k]}) begin
                n_fail++; $display("FAIL w_bp[%0d]: got v=%b d=%h s=%h r=%b expected v=1 d=%h s=%h r=%b",
                    k, m_wvalid, m_wdata, m_wstrb, s_wready, wd[ei[k]], ws[ei[k]], er[k]);
            end
            if (k < 2) begin
                s_wdata = wd[k+1];
                s_wstrb = ws[k+1];
            end
            if (k == 2) m_wready = 1'b1;
            if (k == 4) s_wvalid = 1'b0;
        end
        @(negedge aclk);
        n_chk++;
        if ({m_wvalid, s_wready} !== 2'b01) begin
            n_fail++; $display("FAIL w_drain: got v=%b r=%b expected v=0 r=1", m_wvalid, s_wready);
        end
    endtask

    task automatic test_r_hold;
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEADBEEF;
        m_rresp  = 2'd2;
        s_rready = 1'b0;
        #1;
        n_chk++;
        if (m_rready !== 1'b1) begin
            n_fail++; $display("FAIL r_ready_empty: got %b expected 1", m_rready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            n_chk++;
            if ({s_rvalid, s_rdata, s_rresp, m_rready} !== {1'b1, 32'hDEADBEEF, 2'd2, 1'b0}) begin
                n_fail++; $display("FAIL r_hold[%0d]: got v=%b d=%h resp=%0d r=%b expected v=1 d=deadbeef resp=2 r=0",
                    k, s_rvalid, s_rdata, s_rresp, m_rready);
            end
            if (k == 0) begin
                m_rvalid = 1'b0;
                m_rdata  = 32'h1234_5678;
                m_rresp  = 2'd0;
            end
            if (k == 2) s_rready = 1'b1;
        end
        @(negedge aclk);
        n_chk++;
        if ({s_rvalid, m_rready} !== 2'b01) begin
            n_fail++; $display("FAIL r_release: got v=%b r=%b expected v=0 r=1", s_rvalid, m_rready);
        end
    endtask

    task automatic test_bypass;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            s_awaddr = $urandom; s_wdata = $urandom; s_araddr = $urandom; m_rdata = $urandom;
            s_wstrb = 4'($urandom); m_bresp = 2'($urandom); m_rresp = 2'($urandom);
            {s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid} = 5'($urandom);
            {s_bready, s_rready, m_awready, m_wready, m_arready} = 5'($urandom);
            #1;
            n_chk++;
            if ({m_awaddr_z, m_awvalid_z, m_wdata_z, m_wstrb_z, m_wvalid_z, m_araddr_z, m_arvalid_z,
                 s_bresp_z, s_bvalid_z, s_rdata_z, s_rresp_z, s_rvalid_z,
                 s_awready_z, s_wready_z, s_arready_z, m_bready_z, m_rready_z} !==
                {s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_araddr, s_arvalid,
                 m_bresp, m_bvalid, m_rdata, m_rresp, m_rvalid,
                 m_awready, m_wready, m_arready, s_bready, s_rready}) begin
                n_fail++; $display("FAIL bypass[%0d]: got %h expected %h", i,
                    {m_awaddr_z, m_awvalid_z, m_wdata_z, m_wstrb_z, m_wvalid_z, m_araddr_z, m_arvalid_z,
                     s_bresp_z, s_bvalid_z, s_rdata_z, s_rresp_z, s_rvalid_z,
                     s_awready_z, s_wready_z, s_arready_z, m_bready_z, m_rready_z},
                    {s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_araddr, s_arvalid,
                     m_bresp, m_bvalid, m_rdata, m_rresp, m_rvalid,
                     m_awready, m_wready, m_arready, s_bready, s_rready});
            end
        end
        idle();
    endtask

    task automatic test_reset_mid;
        idle();
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        m_wready = 1'b0;
        s_wvalid = 1'b1;
        s_wdata  = 32'hBAD0_0001;
        @(negedge aclk);
        s_wdata  = 32'hBAD0_0002;
        @(negedge aclk);
        n_chk++;
        if ({m_wvalid, s_wready} !== 2'b10) begin
            n_fail++; $display("FAIL w_full: got v=%b r=%b expected v=1 r=0", m_wvalid, s_wready);
        end
        s_wvalid = 1'b0;
        m_wready = 1'b1;
        areset   = 1'b1;
        @(negedge aclk);
        n_chk++;
        if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid, s_awready, s_wready, s_arready, m_wdata} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got valids=%b readies=%b wdata=%h expected all 0",
                {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, {s_awready, s_wready, s_arready}, m_wdata);
        end
        areset = 1'b0;
        @(negedge aclk);
        n_chk++;
        if ({m_wvalid, s_wready} !== 2'b01) begin
            n_fail++; $display("FAIL mid_release: got v=%b r=%b expected v=0 r=1", m_wvalid, s_wready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_chk++;
            if (m_wvalid !== 1'b0) begin
                n_fail++; $display("FAIL stale_beat[%0d]: got v=%b d=%h expected v=0", i, m_wvalid, m_wdata);
            end
        end
    endtask

    task automatic test_random;
        logic [35:0] qw [$];
        logic [33:0] qr [$];
        logic [35:0] w_prev, w_exp;
        logic [33:0] r_prev, r_exp;
        logic w_hold, r_hold, w_stall, r_stall;
        int nw, nr;
        idle();
        {w_hold, r_hold, w_stall, r_stall} = '0;
        w_prev = '0; r_prev = '0; nw = 0; nr = 0;
        for (int c = 0; c < 10008; c++) begin
            @(negedge aclk);
            if (!w_hold) begin
                s_wvalid = (c < 10000) && ($urandom_range(0, 1) == 1);
                s_wdata  = $urandom;
                s_wstrb  = 4'($urandom);
            end
            if (!r_hold) begin
                m_rvalid = (c < 10000) && ($urandom_range(0, 1) == 1);
                m_rdata  = $urandom;
                m_rresp  = 2'($urandom);
            end
            m_wready = (c >= 10000) || ($urandom_range(0, 3) != 0);
            s_rready = (c >= 10000) || ($urandom_range(0, 3) != 0);
            #4;
            if (s_wvalid && s_wready) qw.push_back({s_wdata, s_wstrb});
            if (m_rvalid && m_rready) qr.push_back({m_rdata, m_rresp});
            if (w_stall) begin
                n_chk++;
                if ({m_wvalid, m_wdata, m_wstrb} !== {1'b1, w_prev}) begin
                    n_fail++; $display("FAIL w_stable@%0d: got v=%b %h expected v=1 %h", c, m_wvalid, {m_wdata, m_wstrb}, w_prev);
                end
            end
            if (r_stall) begin
                n_chk++;
                if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, r_prev}) begin
                    n_fail++; $display("FAIL r_stable@%0d: got v=%b %h expected v=1 %h", c, s_rvalid, {s_rdata, s_rresp}, r_prev);
                end
            end
            if (m_wvalid && m_wready) begin
                w_exp = (qw.size() == 0) ? 'x : qw.pop_front();
                nw++;
                n_chk++;
                if ({m_wdata, m_wstrb} !== w_exp) begin
                    n_fail++; $display("FAIL w_order@%0d: got %h expected %h", c, {m_wdata, m_wstrb}, w_exp);
                end
            end
            if (s_rvalid && s_rready) begin
                r_exp = (qr.size() == 0) ? 'x : qr.pop_front();
                nr++;
                n_chk++;
                if ({s_rdata, s_rresp} !== r_exp) begin
                    n_fail++; $display("FAIL r_order@%0d: got %h expected %h", c, {s_rdata, s_rresp}, r_exp);
                end
            end
            w_stall = m_wvalid && !m_wready;
            r_stall = s_rvalid && !s_rready;
            w_prev  = {m_wdata, m_wstrb};
            r_prev  = {s_rdata, s_rresp};
            w_hold  = s_wvalid && !s_wready;
            r_hold  = m_rvalid && !m_rready;
        end
        n_chk++;
        if (qw.size() != 0 || qr.size() != 0 || nw < 2000 || nr < 2000) begin
            n_fail++; $display("FAIL random_drain: got w_left=%0d r_left=%0d w_beats=%0d r_beats=%0d expected 0 0 >=2000 >=2000",
                qw.size(), qr.size(), nw, nr);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_aw_stream();
        test_w_backpressure();
        test_r_hold();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
